// File: rtl/spi_slave_fsm_if.sv
// SPI slave front-end bus: serial pins plus the command/read-data handshake
// toward the single-port RAM. Optional macro SPI_ABORT_FLAG_EN adds abort_err.
interface spi_slave_fsm_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
);
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;
`ifdef SPI_ABORT_FLAG_EN
    logic            abort_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, abort_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, abort_err
    );
`else
    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
`endif
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: deserialises SS_n-framed MOSI frames into
// RX_W-bit command words and shifts the RAM read byte out on MISO, MSB first.
// Optional macro SPI_ABORT_FLAG_EN adds a one-cycle abort_err pulse when a
// frame or shift-out is cut short by SS_n rising.
module spi_slave_fsm #(
    parameter int RX_W        = 10,
    parameter int TX_W        = 8,
    parameter int TX_WAIT_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Sub-phase inside the data states: receiving bits, waiting for the RAM
    // read byte, shifting it out, or finished and waiting for SS_n to rise.
    typedef enum logic [1:0] {
        PH_RX    = 2'd0,
        PH_WAIT  = 2'd1,
        PH_SHIFT = 2'd2,
        PH_DONE  = 2'd3
    } phase_t;

    // One counter serves bit reception, the tx_valid wait and the shift-out.
    localparam int MAX_A   = ((RX_W - 1) > TX_W) ? (RX_W - 1) : TX_W;
    localparam int CNT_MAX = (MAX_A > TX_WAIT_MAX) ? MAX_A : TX_WAIT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TX_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] TX_LEN    = CNT_W'(TX_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RX_W-1:0]   rx_sr_q, rx_sr_d;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [TX_W-1:0]   tx_sr_q, tx_sr_d;
    logic              miso_q, miso_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic              abort_q, abort_d;
    logic              ss_abort;

    // SS_n high outside IDLE terminates whatever the FSM is doing.
    assign ss_abort = (state_q != IDLE) && bus.SS_n;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame start, command decode and SS_n abort.
    always_comb begin
        state_d = state_q;
        if (ss_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    if (!bus.MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output/datapath logic: bit shifting, word capture, read handshake, MISO.
    always_comb begin
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        rx_sr_d        = rx_sr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        tx_sr_d        = tx_sr_q;
        miso_d         = miso_q;
        rd_addr_seen_d = rd_addr_seen_q;
        abort_d        = 1'b0;
        if (ss_abort) begin
            // Partial frames are dropped; a completed frame keeps its effects.
            phase_d = PH_RX;
            cnt_d   = '0;
            miso_d  = 1'b0;
            abort_d = (phase_q == PH_RX) || (phase_q == PH_SHIFT);
        end else begin
            case (state_q)
                IDLE: begin
                    phase_d = PH_RX;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                end
                CHK_CMD: begin
                    rx_sr_d = {rx_sr_q[RX_W-2:0], bus.MOSI};
                    cnt_d   = '0;
                    phase_d = PH_RX;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    case (phase_q)
                        PH_RX: begin
                            if (cnt_q != RX_LAST) begin
                                rx_sr_d = {rx_sr_q[RX_W-2:0], bus.MOSI};
                                cnt_d   = cnt_q + CNT_ONE;
                            end else begin
                                rx_data_d  = rx_sr_q;
                                rx_valid_d = 1'b1;
                                cnt_d      = '0;
                                if (state_q == READ_ADD) begin
                                    rd_addr_seen_d = 1'b1;
                                end
                                if (state_q == READ_DATA) begin
                                    rd_addr_seen_d = 1'b0;
                                    phase_d        = PH_WAIT;
                                end else begin
                                    phase_d = PH_DONE;
                                end
                            end
                        end
                        PH_WAIT: begin
                            if (bus.tx_valid) begin
                                tx_sr_d = bus.tx_data;
                                cnt_d   = '0;
                                phase_d = PH_SHIFT;
                            end else if (cnt_q == WAIT_LAST) begin
                                phase_d = PH_DONE;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                        PH_SHIFT: begin
                            if (cnt_q != TX_LEN) begin
                                miso_d  = tx_sr_q[TX_W-1];
                                tx_sr_d = {tx_sr_q[TX_W-2:0], 1'b0};
                                cnt_d   = cnt_q + CNT_ONE;
                            end else begin
                                miso_d  = 1'b0;
                                cnt_d   = '0;
                                phase_d = PH_DONE;
                            end
                        end
                        default: begin
                            miso_d = 1'b0;
                        end
                    endcase
                end
                default: begin
                    phase_d = PH_RX;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q        <= PH_RX;
            cnt_q          <= '0;
            rx_sr_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_sr_q        <= '0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            rx_sr_q        <= rx_sr_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            tx_sr_q        <= tx_sr_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            abort_q        <= abort_d;
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

`ifdef SPI_ABORT_FLAG_EN
    assign bus.abort_err = abort_q;
`else
    logic unused_abort;
    assign unused_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: write, read-address/read-data with
// shift-out, abort, read timeout, and reset during frame and shift-out.
module tb_spi_slave_fsm;

    localparam int RX_W        = 10;
    localparam int TX_W        = 8;
    localparam int TX_WAIT_MAX = 4;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_CHK   = 32'd1;
    localparam logic [31:0] S_WRITE = 32'd2;
    localparam logic [31:0] S_RADD  = 32'd3;
    localparam logic [31:0] S_RDAT  = 32'd4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    spi_slave_fsm_if #(.RX_W(RX_W), .TX_W(TX_W)) bus ();

    spi_slave_fsm #(
        .RX_W(RX_W),
        .TX_W(TX_W),
        .TX_WAIT_MAX(TX_WAIT_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one full frame; leaves SS_n low after the rx_valid cycle.
    task automatic frame(input logic [9:0] w, input logic [31:0] exp_st, input string tag);
        bus.SS_n = 1'b0;
        bus.MOSI = w[9];
        step();
        chk({tag, "_chk_state"}, 32'(dut.state_q), S_CHK);
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = w[i];
            step();
            if (i == 9) chk({tag, "_state"}, 32'(dut.state_q), exp_st);
            if (i == 0) chk({tag, "_early_valid"}, 32'(bus.rx_valid), 32'd0);
        end
        step();
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(w));
        chk({tag, "_miso"}, 32'(bus.MISO), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        step();
        chk({tag, "_idle"}, 32'(dut.state_q), S_IDLE);
        chk({tag, "_valid_low"}, 32'(bus.rx_valid), 32'd0);
`ifdef SPI_ABORT_FLAG_EN
        chk({tag, "_no_abort"}, 32'(bus.abort_err), 32'd0);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        step();
        step();
        chk("rst_state", 32'(dut.state_q), S_IDLE);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
`ifdef SPI_ABORT_FLAG_EN
        chk("rst_abort", 32'(bus.abort_err), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Write address
        frame(10'h055, S_WRITE, "wr_addr");
        end_frame("wr_addr");

        // Write data, with a stray tx_valid that must be ignored
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        frame(10'h1AA, S_WRITE, "wr_data");
        chk("wr_data_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        step();
        chk("wr_data_single_pulse", 32'(bus.rx_valid), 32'd0);
        chk("wr_data_miso", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        end_frame("wr_data");
        chk("wr_data_hold", 32'(bus.rx_data), 32'h1AA);

        // Read address
        frame(10'h203, S_RADD, "rd_addr");
        chk("rd_addr_seen_set", 32'(dut.rd_addr_seen_q), 32'd1);
        end_frame("rd_addr");
        chk("rd_addr_seen_kept", 32'(dut.rd_addr_seen_q), 32'd1);

        // Read data with shift-out of 8'hC5
        frame(10'h3A5, S_RDAT, "rd_data");
        chk("rd_data_seen_clr", 32'(dut.rd_addr_seen_q), 32'd0);
        step();
        chk("rd_data_pulse_end", 32'(bus.rx_valid), 32'd0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC5;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        chk("rd_data_pre_shift", 32'(bus.MISO), 32'd0);
        exp_byte = 8'hC5;
        for (int i = 7; i >= 0; i--) begin
            bus.MOSI = 1'($urandom_range(0, 1));
            step();
            chk($sformatf("rd_data_miso_b%0d", i), 32'(bus.MISO), 32'(exp_byte[i]));
        end
        step();
        chk("rd_data_miso_after", 32'(bus.MISO), 32'd0);
        chk("rd_data_stay", 32'(dut.state_q), S_RDAT);
        end_frame("rd_data");

        // Abort after 5 bits of a write frame, then restart on the next edge
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        step();
        begin
            logic [9:0] w;
            w = 10'h0AB;
            for (int i = 9; i >= 5; i--) begin
                bus.MOSI = w[i];
                step();
            end
        end
        bus.SS_n = 1'b1;
        step();
        chk("abort_idle", 32'(dut.state_q), S_IDLE);
        chk("abort_no_valid", 32'(bus.rx_valid), 32'd0);
        chk("abort_rx_data_kept", 32'(bus.rx_data), 32'h3A5);
`ifdef SPI_ABORT_FLAG_EN
        chk("abort_flag", 32'(bus.abort_err), 32'd1);
`endif
        frame(10'h0F0, S_WRITE, "restart");
        end_frame("restart");

        // Read timeout: tx_valid arrives one edge past the wait window
        frame(10'h2AA, S_RADD, "to_addr");
        end_frame("to_addr");
        frame(10'h3FF, S_RDAT, "to_data");
        chk("to_seen_clr", 32'(dut.rd_addr_seen_q), 32'd0);
        for (int i = 0; i < TX_WAIT_MAX; i++) begin
            step();
            chk("to_wait_miso", 32'(bus.MISO), 32'd0);
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("to_late_miso", 32'(bus.MISO), 32'd0);
        end
        end_frame("to_data");
        frame(10'h201, S_RADD, "to_next");

        // Reset mid-frame after a completed read-address
        step();
        chk("rst_mid_seen_before", 32'(dut.rd_addr_seen_q), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_state", 32'(dut.state_q), S_IDLE);
        chk("rst_mid_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        chk("rst_mid_rx_data", 32'(bus.rx_data), 32'd0);
        step();
        rst      = 1'b0;
        bus.SS_n = 1'b1;
        step();

        // Reset during MISO bit 3 of 8'hC5
        frame(10'h203, S_RADD, "rs_addr");
        end_frame("rs_addr");
        frame(10'h3C0, S_RDAT, "rs_data");
        step();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC5;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int i = 7; i >= 3; i--) begin
            step();
            chk($sformatf("rs_miso_b%0d", i), 32'(bus.MISO), 32'(exp_byte[i]));
        end
        rst = 1'b1;
        #1;
        chk("rs_state", 32'(dut.state_q), S_IDLE);
        chk("rs_miso", 32'(bus.MISO), 32'd0);
        chk("rs_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rs_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        chk("rs_rx_data", 32'(bus.rx_data), 32'd0);
        step();
        rst      = 1'b0;
        bus.SS_n = 1'b1;
        step();
        chk("rs_hold_valid", 32'(bus.rx_valid), 32'd0);

        // Recovery frame
        frame(10'h155, S_WRITE, "recover");
        end_frame("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
Serial front end of the SPI slave wrapper. It deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the downstream single-port RAM. It accepts the RAM's read byte (tx_data/tx_valid) and serialises it MSB-first on MISO. The block is clocked directly by the SPI clock, and SS_n frames every transaction.

Parameters:
RX_W, 10, command word width: bits[9:8] opcode, bits[7:0] payload.
TX_W, 8, read-data width shifted out on MISO.
TX_WAIT_MAX, 4, cycles to wait for tx_valid after a read-data command before giving up.

Ports:
clk  input  1  SPI/system clock, rising-edge active.
rst  input  1  asynchronous reset, active-high.
SS_n  input  1  slave select, active-low; high aborts any frame.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first.
rx_data  output  RX_W  assembled command word to RAM.
rx_valid  output  1  one-cycle strobe; rx_data is valid while high.
tx_data  input  TX_W  read byte from RAM.
tx_valid  input  1  tx_data valid strobe from RAM.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE, rx_data = 0, rx_valid = 0, MISO = 0, bit counter = 0.
  - rd_addr_seen = 0; tx shift register = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n sampled low moves to CHK_CMD. No bit is captured on this edge.
- CHK_CMD: the MOSI sample becomes bit 9.
  - MOSI = 0 goes to WRITE.
  - MOSI = 1 with rd_addr_seen = 0 goes to READ_ADD.
  - MOSI = 1 with rd_addr_seen = 1 goes to READ_DATA.
- WRITE, READ_ADD and READ_DATA shift in 9 more bits (bits 8..0) on 9 consecutive edges.
  - The edge after bit 0 is captured: rx_data <= shift register, rx_valid = 1 for exactly 1 cycle.
  - rx_data holds its value until the next completed frame.
- Frame latency: SS_n low edge to rx_valid high is 12 clocks (1 to CHK_CMD, 1 for bit 9, 9 for bits 8..0, 1 for the register).
- Frame completes in READ_ADD: rd_addr_seen <= 1. Frame completes in READ_DATA: rd_addr_seen <= 0.
- Opcode bits are forwarded unmodified. The RAM decodes [9:8].
- After rx_valid in READ_DATA, the FSM waits up to TX_WAIT_MAX cycles for tx_valid:
  - On tx_valid, latch tx_data into the shift register.
  - Starting on the next edge, drive MISO with bit 7, then 6, ..., then 0 on 8 consecutive edges.
  - After bit 0, MISO returns to 0 and the FSM stays in READ_DATA until SS_n goes high.
- Timeout (no tx_valid within TX_WAIT_MAX): MISO stays 0, no shift-out occurs, rd_addr_seen is still cleared.
- tx_valid outside READ_DATA-wait is ignored.
- SS_n high in any non-IDLE state:
  - Next state is IDLE; the partial frame is discarded and no rx_valid is produced.
  - The bit counter clears; MISO is driven to 0.
  - rd_addr_seen is unchanged unless the frame had already completed.
- SS_n high and low on consecutive edges: the FSM passes through IDLE, and the new frame starts cleanly.
- Reset mid-frame or mid-shift-out: immediate return to reset values. rx_valid must not glitch high.
- MOSI is ignored in IDLE and during READ_DATA shift-out.

Optional Feature:
SPI_ABORT_FLAG_EN:
- Defined: adds output port abort_err (1 bit, reset 0). It pulses high for 1 cycle on the edge after SS_n rises while a frame is partial (CHK_CMD, or a data state with fewer than 10 bits captured) or during MISO shift-out.
- Undefined: the port and its logic are absent; aborts are silent.

Test Plan:
- Write address: SS_n low, MOSI = 00_0101_0101 → 12 clocks after SS_n falls, rx_valid pulses 1 cycle with rx_data = 10'h055; MISO stays 0.
- Write data: frame 01_1010_1010 → rx_data = 10'h1AA, single rx_valid; rd_addr_seen stays 0.
- Read address then read data:
  - Frame 10_0000_0011 → rx_data = 10'h203, rd_addr_seen = 1.
  - Next frame 11_xxxx_xxxx → rx_valid.
  - Bench returns tx_valid with tx_data = 8'hC5 one cycle later → MISO shows 1,1,0,0,0,1,0,1 on the 8 following edges; rd_addr_seen = 0.
- Abort: SS_n rises after 5 bits of a write frame → no rx_valid, FSM returns to IDLE. With SPI_ABORT_FLAG_EN, abort_err pulses once.
- Read timeout: READ_DATA frame with tx_valid never asserted → MISO remains 0 after TX_WAIT_MAX = 4 cycles, and the next MOSI = 1 frame enters READ_ADD.
- Reset mid-shift: rst asserted during MISO bit 3 of 8'hC5 → MISO = 0, rx_valid = 0, state = IDLE, rd_addr_seen = 0 immediately.
